// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot p1..p5 phase generator with run/step/stop/halt
// control and a retired-instruction counter for the SIMPLE processor core.
module phase_sequencer #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   exec,
    input  logic                   step,
    input  logic [15:0]            instruction,
    output logic                   p1,
    output logic                   p2,
    output logic                   p3,
    output logic                   p4,
    output logic                   p5,
    output logic                   running,
    output logic                   halted,
    output logic [COUNT_WIDTH-1:0] retired
);

    localparam int unsigned PH_W = 5;
    localparam logic [PH_W-1:0] PH_NONE = 5'b00000;
    localparam logic [PH_W-1:0] PH_P1   = 5'b00001;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_STEP   = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t                 r_state;
    logic [PH_W-1:0]        r_phase;
    logic                   r_exec_prev;
    logic                   r_step_prev;
    logic                   r_stop_req;
    logic                   r_running;
    logic                   r_halted;
    logic [COUNT_WIDTH-1:0] r_retired;

    logic w_exec_rise;
    logic w_step_rise;
    logic w_is_halt;
    logic w_phase_ok;
    logic w_unused_instr;

    assign w_exec_rise = exec & ~r_exec_prev;
    assign w_step_rise = step & ~r_step_prev;
    assign w_is_halt   = (instruction[15:14] == 2'b11) && (instruction[7:4] == 4'b1111);
    assign w_phase_ok  = (r_phase != PH_NONE) &&
                         ((r_phase & (r_phase - PH_W'(1))) == PH_NONE);

    // Opcode bits outside the HALT pattern play no part in sequencing.
    assign w_unused_instr = ^{instruction[13:8], instruction[3:0]};

    // Button edge detectors.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exec_prev <= 1'b0;
            r_step_prev <= 1'b0;
        end else begin
            r_exec_prev <= exec;
            r_step_prev <= step;
        end
    end

    // Run/step/halt state machine and phase ring.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= PH_NONE;
            r_stop_req <= 1'b0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_exec_rise) begin
                        r_state    <= S_RUN;
                        r_phase    <= PH_P1;
                        r_running  <= 1'b1;
                        r_stop_req <= 1'b0;
                    end else if (w_step_rise) begin
                        r_state    <= S_STEP;
                        r_phase    <= PH_P1;
                        r_running  <= 1'b1;
                        r_stop_req <= 1'b0;
                    end
                end
                S_RUN, S_STEP: begin
                    if (!w_phase_ok) begin
                        // Corrupted ring: restart the instruction at p1.
                        r_phase <= PH_P1;
                    end else if (r_phase[PH_W-1]) begin
                        if (w_is_halt) begin
                            r_state    <= S_HALTED;
                            r_phase    <= PH_NONE;
                            r_running  <= 1'b0;
                            r_halted   <= 1'b1;
                            r_stop_req <= 1'b0;
                        end else if ((r_state == S_STEP) || r_stop_req || w_exec_rise) begin
                            r_state    <= S_IDLE;
                            r_phase    <= PH_NONE;
                            r_running  <= 1'b0;
                            r_stop_req <= 1'b0;
                        end else begin
                            r_phase <= PH_P1;
                        end
                    end else begin
                        r_phase <= {r_phase[PH_W-2:0], 1'b0};
                        if ((r_state == S_RUN) && w_exec_rise) begin
                            r_stop_req <= 1'b1;
                        end
                    end
                end
                S_HALTED: begin
                    r_phase   <= PH_NONE;
                    r_running <= 1'b0;
                    r_halted  <= 1'b1;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_phase    <= PH_NONE;
                    r_running  <= 1'b0;
                    r_halted   <= 1'b0;
                    r_stop_req <= 1'b0;
                end
            endcase
        end
    end

    // Retired-instruction counter: one count per p5, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_retired <= '0;
        end else if (r_phase[PH_W-1]) begin
            r_retired <= r_retired + COUNT_WIDTH'(1);
        end
    end

    assign p1      = r_phase[0];
    assign p2      = r_phase[1];
    assign p3      = r_phase[2];
    assign p4      = r_phase[3];
    assign p5      = r_phase[4];
    assign running = r_running;
    assign halted  = r_halted;
    assign retired = r_retired;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed vector table plus a counter-wrap sequence.
module tb_phase_sequencer;

    localparam int unsigned CW = 4;
    localparam logic [15:0] ADD  = 16'hC000;
    localparam logic [15:0] HALT = 16'hC0F0;
    localparam logic [4:0]  PN = 5'b00000;
    localparam logic [4:0]  P1 = 5'b00001;
    localparam logic [4:0]  P2 = 5'b00010;
    localparam logic [4:0]  P3 = 5'b00100;
    localparam logic [4:0]  P4 = 5'b01000;
    localparam logic [4:0]  P5 = 5'b10000;

    typedef struct {
        logic          rst;
        logic          ex;
        logic          st;
        logic [15:0]   instr;
        logic [4:0]    ph;
        logic          run;
        logic          hlt;
        logic [CW-1:0] ret;
    } vec_t;

    logic          clock;
    logic          reset;
    logic          exec;
    logic          step;
    logic [15:0]   instruction;
    logic          p1, p2, p3, p4, p5;
    logic          running;
    logic          halted;
    logic [CW-1:0] retired;

    int n_vec;
    int n_err;
    vec_t tbl[$];

    phase_sequencer #(.COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .exec        (exec),
        .step        (step),
        .instruction (instruction),
        .p1          (p1),
        .p2          (p2),
        .p3          (p3),
        .p4          (p4),
        .p5          (p5),
        .running     (running),
        .halted      (halted),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic void v(input logic rst, input logic ex, input logic st,
                              input logic [15:0] instr, input logic [4:0] ph,
                              input logic run, input logic hlt, input int ret);
        vec_t e;
        e.rst = rst; e.ex = ex; e.st = st; e.instr = instr;
        e.ph = ph; e.run = run; e.hlt = hlt; e.ret = CW'(ret);
        tbl.push_back(e);
    endfunction

    // Drive inputs away from the edge, sample 1 time unit after it.
    task automatic apply(input string name, input logic rst, input logic ex, input logic st,
                         input logic [15:0] instr, input logic [4:0] ph,
                         input logic run, input logic hlt, input logic [CW-1:0] ret);
        @(negedge clock);
        reset = rst; exec = ex; step = st; instruction = instr;
        @(posedge clock);
        #1;
        n_vec++;
        if ({p5, p4, p3, p2, p1} !== ph || running !== run || halted !== hlt || retired !== ret) begin
            n_err++;
            $display("FAIL %s: got ph=%b run=%b hlt=%b ret=%0d, expected ph=%b run=%b hlt=%b ret=%0d",
                     name, {p5, p4, p3, p2, p1}, running, halted, retired, ph, run, hlt, ret);
        end
    endtask

    initial begin
        logic [4:0] ring[5];
        ring[0] = P1; ring[1] = P2; ring[2] = P3; ring[3] = P4; ring[4] = P5;
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; exec = 1'b0; step = 1'b0; instruction = ADD;

        // reset state
        v(1,0,0,ADD, PN,0,0,0);
        v(1,0,0,ADD, PN,0,0,0);
        v(0,0,0,ADD, PN,0,0,0);
        // exec held high three cycles: one rise only; three full instructions
        v(0,1,0,ADD, P1,1,0,0); v(0,1,0,ADD, P2,1,0,0); v(0,1,0,ADD, P3,1,0,0);
        v(0,0,0,ADD, P4,1,0,0); v(0,0,0,ADD, P5,1,0,0);
        v(0,0,0,ADD, P1,1,0,1); v(0,0,0,ADD, P2,1,0,1); v(0,0,0,ADD, P3,1,0,1);
        v(0,0,0,ADD, P4,1,0,1); v(0,0,0,ADD, P5,1,0,1);
        v(0,0,0,ADD, P1,1,0,2); v(0,0,0,ADD, P2,1,0,2); v(0,0,0,ADD, P3,1,0,2);
        v(0,0,0,ADD, P4,1,0,2); v(0,0,0,ADD, P5,1,0,2);
        v(0,0,0,ADD, P1,1,0,3);
        // stop: exec rise sampled during p2
        v(0,0,0,ADD, P2,1,0,3);
        v(0,1,0,ADD, P3,1,0,3);
        v(0,0,0,ADD, P4,1,0,3); v(0,0,0,ADD, P5,1,0,3);
        v(0,0,0,ADD, PN,0,0,4); v(0,0,0,ADD, PN,0,0,4);
        // single step
        v(0,0,1,ADD, P1,1,0,4); v(0,0,0,ADD, P2,1,0,4); v(0,0,0,ADD, P3,1,0,4);
        v(0,0,0,ADD, P4,1,0,4); v(0,0,0,ADD, P5,1,0,4);
        v(0,0,0,ADD, PN,0,0,5);
        // second step, exec rise inside STEP ignored
        v(0,0,1,ADD, P1,1,0,5); v(0,1,0,ADD, P2,1,0,5); v(0,0,0,ADD, P3,1,0,5);
        v(0,0,0,ADD, P4,1,0,5); v(0,0,0,ADD, P5,1,0,5);
        v(0,0,0,ADD, PN,0,0,6); v(0,0,0,ADD, PN,0,0,6);
        // HALT in RUN; HALT on the bus before p5 has no effect
        v(0,1,0,ADD,  P1,1,0,6); v(0,0,0,HALT, P2,1,0,6); v(0,0,0,HALT, P3,1,0,6);
        v(0,0,0,HALT, P4,1,0,6); v(0,0,0,HALT, P5,1,0,6);
        v(0,0,0,HALT, PN,0,1,7);
        v(0,1,0,HALT, PN,0,1,7); v(0,0,0,ADD, PN,0,1,7);
        v(0,0,1,ADD,  PN,0,1,7); v(0,0,0,ADD, PN,0,1,7);
        // reset out of HALTED, then reset during p3
        v(1,0,0,ADD, PN,0,0,0); v(0,0,0,ADD, PN,0,0,0);
        v(0,1,0,ADD, P1,1,0,0); v(0,0,0,ADD, P2,1,0,0); v(0,0,0,ADD, P3,1,0,0);
        v(1,0,0,ADD, PN,0,0,0); v(0,0,0,ADD, PN,0,0,0);
        // restart; a step rise in RUN is ignored
        v(0,1,0,ADD, P1,1,0,0); v(0,0,0,ADD, P2,1,0,0); v(0,0,1,ADD, P3,1,0,0);
        v(0,0,0,ADD, P4,1,0,0); v(0,0,0,ADD, P5,1,0,0);
        v(0,0,0,ADD, P1,1,0,1);
        v(0,1,0,ADD, P2,1,0,1); v(0,0,0,ADD, P3,1,0,1);
        v(0,0,0,ADD, P4,1,0,1); v(0,0,0,ADD, P5,1,0,1);
        v(0,0,0,ADD, PN,0,0,2);
        // simultaneous exec and step rise: exec wins, RUN continues
        v(0,1,1,ADD, P1,1,0,2); v(0,0,0,ADD, P2,1,0,2); v(0,0,0,ADD, P3,1,0,2);
        v(0,0,0,ADD, P4,1,0,2); v(0,0,0,ADD, P5,1,0,2);
        v(0,0,0,ADD, P1,1,0,3);
        v(0,1,0,ADD, P2,1,0,3); v(0,0,0,ADD, P3,1,0,3);
        v(0,0,0,ADD, P4,1,0,3); v(0,0,0,ADD, P5,1,0,3);
        v(0,0,0,ADD, PN,0,0,4);

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ex, tbl[i].st, tbl[i].instr,
                  tbl[i].ph, tbl[i].run, tbl[i].hlt, tbl[i].ret);
        end

        // Counter wrap: 16 instructions from reset, edge k gives phase (k-1)%5, count (k-1)/5.
        apply("wrap_rst", 1'b1, 1'b0, 1'b0, ADD, PN, 1'b0, 1'b0, CW'(0));
        for (int k = 1; k <= 82; k++) begin
            apply($sformatf("wrap_k%0d", k), 1'b0, (k == 1) ? 1'b1 : 1'b0, 1'b0, ADD,
                  ring[(k - 1) % 5], 1'b1, 1'b0, CW'((k - 1) / 5));
        end
        // after edge 81 the count has wrapped from 0xF to 0 at p1
        // request stop and wait (bounded) for the machine to fall idle
        @(negedge clock);
        exec = 1'b1;
        @(negedge clock);
        exec = 1'b0;
        begin
            int budget;
            budget = 0;
            while (running === 1'b1 && budget < 20) begin
                @(posedge clock);
                #1;
                budget++;
            end
            n_vec++;
            if (running !== 1'b0 || {p5, p4, p3, p2, p1} !== PN || retired !== CW'(1)) begin
                n_err++;
                $display("FAIL wrap_stop: got run=%b ph=%b ret=%0d after %0d cycles, expected run=0 ph=00000 ret=1",
                         running, {p5, p4, p3, p2, p1}, retired, budget);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
